psum_ppu: RTL and testbench
===========================

PSUM_PPU -- requirements
Module: psum_ppu

Interface
REQ-001 The block SHALL have parameter LANES, default 4: int8 lanes per output word, fixed at 4.
REQ-002 The block SHALL have parameter ZP, default 8'h80: offset added to each int8 result before packing.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 cfg_en  input  1  configuration load strobe, sampled only in IDLE.
REQ-006 i_scale  input  16  unsigned requantization multiplier.
REQ-007 i_shift  input  5  right-shift amount, 0..31.
REQ-008 i_relu  input  1  ReLU enable.
REQ-009 i_len  input  10  psums per frame minus 1, giving 1..1024 psums.
REQ-010 ipsum  input  32  signed psum from PE opsum.
REQ-011 ipsum_valid  input  1  ipsum is valid.
REQ-012 ipsum_ready  output  1  block accepts ipsum this cycle.
REQ-013 out_data  output  32  packed 4 x uint8 result word.
REQ-014 out_valid  output  1  out_data is valid.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 busy  output  1  high when the state is not IDLE.
REQ-017 done  output  1  one-cycle pulse at frame completion.

Function
REQ-018 States SHALL be IDLE, RUN and DONE.
REQ-019 IDLE->RUN SHALL occur on cfg_en=1; i_scale, i_shift, i_relu and i_len SHALL be latched that cycle; cfg_en outside IDLE SHALL be ignored.
REQ-020 ipsum_ready SHALL equal (state==RUN) && (in_ct <= len) && (!out_valid || out_ready).
REQ-021 An ipsum accept SHALL occur on ipsum_valid && ipsum_ready; in_ct SHALL count accepts from 0.
REQ-022 Arithmetic per accepted psum: prod = signed 48-bit ipsum*{0,scale}; if shift>0, add 2^(shift-1); arithmetic shift right by shift (round half toward +inf).
REQ-023 If relu=1, a negative shifted value SHALL become 0.
REQ-024 The value SHALL then be clamped to [-128,127]; byte = clamped + ZP, modulo 256.
REQ-025 The byte SHALL be written to pack lane lane_ct, bits [8*lane_ct+7 : 8*lane_ct], in the accept cycle; the first psum of each word goes to lane 0.
REQ-026 When lane_ct==3 or in_ct==len, the completed word SHALL load out_data on the next edge and out_valid SHALL be set.
REQ-027 Unfilled lanes of a final partial word SHALL be 8'h80.
REQ-028 After a word is emitted, lane_ct SHALL return to 0 and the pack register SHALL be refilled with 32'h80808080.
REQ-029 out_data SHALL hold stable while out_valid && !out_ready.
REQ-030 out_valid SHALL clear on handshake unless a new word loads in the same cycle.
REQ-031 An accept and an output handshake in the same cycle SHALL both complete, with zero bubbles.
REQ-032 Throughput SHALL be 1 psum/cycle with out_ready held high; latency SHALL be 1 cycle from the last-lane accept to out_valid.
REQ-033 RUN->DONE SHALL occur on handshake of the word containing psum number len.
REQ-034 In DONE, done=1 for one cycle, then the state SHALL go to IDLE.
REQ-035 ipsum_valid in IDLE or DONE SHALL be ignored, with ipsum_ready=0.

Reset
REQ-036 On rst=0 the block SHALL immediately set state=IDLE, and clear in_ct, lane_ct and all config registers.
REQ-037 On rst=0 the pack register SHALL be set to 32'h80808080 and out_data to 0.
REQ-038 On rst=0, out_valid, ipsum_ready, busy and done SHALL be 0.
REQ-039 Reset mid-frame SHALL discard partial words with no output emitted; the next frame SHALL require a new cfg_en.

Verification
REQ-040 Basic packing: scale=1, shift=0, relu=0, len=3; psums 1, -1, 127, -128 -> single word 32'h00FF7F81, then done pulse.
REQ-041 Rounding: scale=3, shift=2, len=1; psums 5, -5 -> bytes 0x84, 0x7C; word 32'h80807C84.
REQ-042 Clamp and ReLU:
  relu=1, scale=1, shift=0; psums -50, 100000 -> bytes 0x80, 0xFF.
  relu=0; psum -100000 -> 0x00.
REQ-043 Partial flush: scale=1, len=5; six psums of 1 -> 32'h81818181 then 32'h80808181, done once, busy low after.
REQ-044 Backpressure: out_ready=0 for 5 cycles with a word pending -> out_data stable, ipsum_ready=0; release -> streaming resumes with no lost or duplicated byte.
REQ-045 Reset mid-frame: rst=0 after 2 accepts of len=3 -> out_valid=0, busy=0, no word emitted; a new frame then produces correct output.

Source files
------------

// File: rtl/psum_ppu.sv
// psum_ppu: partial-sum post-processing unit.
// Requantizes a stream of signed 32-bit partial sums to uint8 (scale, rounded
// arithmetic shift, optional ReLU, clamp to int8, add zero point) and packs
// four results per 32-bit output word. Frames are configured with cfg_en in
// IDLE and run for i_len+1 partial sums; a final partial word is padded with
// 8'h80 lanes.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   cfg_en       config load strobe (IDLE only)
//   i_scale      unsigned 16-bit multiplier
//   i_shift      right shift amount 0..31
//   i_relu       clamp negatives to zero before saturation
//   i_len        psums per frame minus 1
//   ipsum        signed 32-bit partial sum
//   ipsum_valid  / ipsum_ready   input handshake
//   out_data     packed 4 x uint8, lane 0 in bits [7:0]
//   out_valid    / out_ready     output handshake
//   busy         state is not IDLE
//   done         one-cycle pulse at frame completion
module psum_ppu #(
  parameter int          LANES = 4,
  parameter logic [7:0]  ZP    = 8'h80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_en,
  input  logic [15:0] i_scale,
  input  logic [4:0]  i_shift,
  input  logic        i_relu,
  input  logic [9:0]  i_len,
  input  logic [31:0] ipsum,
  input  logic        ipsum_valid,
  output logic        ipsum_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0]  LAST_LANE = 2'(LANES - 1);
  localparam logic [31:0] PACK_FILL = 32'h8080_8080;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] scale_q, scale_d;
  logic [4:0]  shift_q, shift_d;
  logic        relu_q, relu_d;
  logic [9:0]  len_q, len_d;
  // One bit wider than len so it can count past the last psum (up to 1024).
  logic [10:0] in_ct_q, in_ct_d;
  logic [1:0]  lane_ct_q, lane_ct_d;
  logic [31:0] pack_q, pack_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  // Set while the word currently in out_data carries the frame's last psum.
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic               accept;
  logic               out_hs;
  logic               last_psum;
  logic signed [48:0] prod;
  logic signed [48:0] rq;
  logic signed [7:0]  sat;
  logic [7:0]         q_byte;
  logic [31:0]        pack_word;

  // Add half an LSB of the result (2^(sh-1)) then floor-shift: round half up.
  function automatic logic signed [48:0] round_shift(input logic signed [48:0] v,
                                                     input logic [4:0] sh);
    logic signed [48:0] bias;
    bias = (sh != 5'd0) ? (49'sd1 <<< (sh - 5'd1)) : 49'sd0;
    return (v + bias) >>> sh;
  endfunction

  function automatic logic signed [7:0] sat_s8(input logic signed [48:0] v);
    if (v > 49'sd127)
      return 8'sd127;
    else if (v < -49'sd128)
      return -8'sd128;
    else
      return $signed(v[7:0]);
  endfunction

  assign ipsum_ready = (state_q == S_RUN) && (in_ct_q <= {1'b0, len_q}) &&
                       (!out_valid_q || out_ready);
  assign accept      = ipsum_valid && ipsum_ready;
  assign out_hs      = out_valid_q && out_ready;
  assign last_psum   = (in_ct_q == {1'b0, len_q});

  // Requantization datapath for the psum presented this cycle.
  always_comb begin
    prod = $signed({{17{ipsum[31]}}, ipsum}) * $signed({33'd0, scale_q});
    rq   = round_shift(prod, shift_q);
    if (relu_q && (rq < 49'sd0))
      rq = 49'sd0;
    sat       = sat_s8(rq);
    q_byte    = sat + ZP;
    pack_word = pack_q;
    pack_word[{lane_ct_q, 3'b000} +: 8] = q_byte;
  end

  always_comb begin
    state_d     = state_q;
    scale_d     = scale_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    len_d       = len_q;
    in_ct_d     = in_ct_q;
    lane_ct_d   = lane_ct_q;
    pack_d      = pack_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_en) begin
          scale_d   = i_scale;
          shift_d   = i_shift;
          relu_d    = i_relu;
          len_d     = i_len;
          in_ct_d   = '0;
          lane_ct_d = '0;
          pack_d    = PACK_FILL;
          last_d    = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          if (last_q)
            state_d = S_DONE;
        end
        // An accept is only possible when the output slot frees this cycle,
        // so loading a new word here never overwrites an unsent one.
        if (accept) begin
          in_ct_d = in_ct_q + 11'd1;
          if ((lane_ct_q == LAST_LANE) || last_psum) begin
            out_data_d  = pack_word;
            out_valid_d = 1'b1;
            pack_d      = PACK_FILL;
            lane_ct_d   = '0;
            last_d      = last_psum;
          end else begin
            pack_d    = pack_word;
            lane_ct_d = lane_ct_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      scale_q     <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      len_q       <= '0;
      in_ct_q     <= '0;
      lane_ct_q   <= '0;
      pack_q      <= PACK_FILL;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      scale_q     <= scale_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      len_q       <= len_d;
      in_ct_q     <= in_ct_d;
      lane_ct_q   <= lane_ct_d;
      pack_q      <= pack_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_psum_ppu.sv
// Testbench for psum_ppu: directed frames with hand-computed words plus
// randomized frames checked against an arithmetic reference model.
module tb_psum_ppu;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic [15:0] i_scale;
  logic [4:0]  i_shift;
  logic        i_relu;
  logic [9:0]  i_len;
  logic [31:0] ipsum;
  logic        ipsum_valid;
  logic        ipsum_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  psum_ppu #(.LANES(4), .ZP(8'h80)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .i_scale(i_scale),
    .i_shift(i_shift), .i_relu(i_relu), .i_len(i_len), .ipsum(ipsum),
    .ipsum_valid(ipsum_valid), .ipsum_ready(ipsum_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int          psums[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requantize one psum from the arithmetic rules: scale, round half up,
  // shift, ReLU, clamp to int8, offset by 128.
  function automatic logic [7:0] ref_byte(input int psum, input int scale,
                                          input int shift, input bit relu);
    longint p;
    p = longint'(psum) * longint'(scale);
    if (shift > 0) p = p + (longint'(1) << (shift - 1));
    p = p >>> shift;
    if (relu && p < 0) p = 0;
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    return 8'(p + 128);
  endfunction

  task automatic model_words(input int scale, input int shift, input bit relu);
    logic [31:0] w;
    for (int i = 0; i < psums.size(); i += 4) begin
      w = 32'h8080_8080;
      for (int l = 0; l < 4; l++)
        if (i + l < psums.size())
          w[8*l +: 8] = ref_byte(psums[i+l], scale, shift, relu);
      exp_q.push_back(w);
    end
  endtask

  task automatic configure(input int scale, input int shift, input bit relu, input int len);
    @(negedge clk);
    cfg_en  = 1'b1;
    i_scale = 16'(scale);
    i_shift = 5'(shift);
    i_relu  = relu;
    i_len   = 10'(len);
    @(posedge clk);
    #1;
    cfg_en = 1'b0;
    chk("busy_after_cfg", 32'(busy), 32'd1);
  endtask

  // Stream psums[] into the DUT and score every output handshake against exp_q.
  task automatic run_frame(input int p_valid, input int p_ready, input int hold);
    int          n;
    int          idx;
    int          cyc;
    int          limit;
    int          hold_left;
    bit          done_seen;
    bit          word_due;
    bit          prev_stall;
    bit          full;
    logic [31:0] prev_data;
    n          = psums.size();
    idx        = 0;
    cyc        = 0;
    limit      = 8 * n + 100;
    hold_left  = hold;
    done_seen  = 1'b0;
    word_due   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    full       = (p_valid == 100) && (p_ready == 100) && (hold == 0);
    while (!done_seen && cyc < limit) begin
      @(negedge clk);
      cyc++;
      ipsum_valid = (idx < n) && ($urandom_range(99) < p_valid);
      ipsum       = (idx < n) ? psums[idx] : $urandom;
      if (out_valid && hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end else begin
        out_ready = ($urandom_range(99) < p_ready);
      end
      // Configuration noise that must be ignored outside IDLE.
      cfg_en  = ($urandom_range(7) == 0);
      i_scale = 16'($urandom);
      i_shift = 5'($urandom);
      i_relu  = 1'($urandom);
      i_len   = 10'($urandom);
      #1;
      if (word_due) chk("out_valid_latency", 32'(out_valid), 32'd1);
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && !out_ready) chk("ready_blocked", 32'(ipsum_ready), 32'd0);
      if (full && idx < n) chk("full_rate_ready", 32'(ipsum_ready), 32'd1);
      word_due = 1'b0;
      if (ipsum_valid && ipsum_ready) begin
        idx++;
        word_due = (idx % 4 == 0) || (idx == n);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_word", out_data, 32'hxxxx_xxxx);
        else                   chk("word", out_data, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) done_seen = 1'b1;
    end
    cfg_en = 1'b0;
    chk("frame_done", 32'(done_seen), 32'd1);
    chk("all_accepted", 32'(idx), 32'(n));
    chk("words_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    ipsum_valid = 1'b1;
    out_ready   = 1'b1;
    @(negedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("idle_ready", 32'(ipsum_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("idle_no_out", 32'(out_valid), 32'd0);
    ipsum_valid = 1'b0;
  endtask

  task automatic set_psums(input int a[$]);
    psums = a;
  endtask

  initial begin
    int scale;
    int shift;
    bit relu;
    int len;
    rst = 1'b0; cfg_en = 1'b0; i_scale = '0; i_shift = '0; i_relu = 1'b0;
    i_len = '0; ipsum = '0; ipsum_valid = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(ipsum_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic packing
    configure(1, 0, 0, 3);
    set_psums('{1, -1, 127, -128});
    exp_q.push_back(32'h00FF_7F81);
    run_frame(100, 100, 0);

    // Rounding half toward +inf
    configure(3, 2, 0, 1);
    set_psums('{5, -5});
    exp_q.push_back(32'h8080_7C84);
    run_frame(100, 100, 0);

    // ReLU and clamp
    configure(1, 0, 1, 1);
    set_psums('{-50, 100000});
    exp_q.push_back(32'h8080_FF80);
    run_frame(100, 100, 0);
    configure(1, 0, 0, 0);
    set_psums('{-100000});
    exp_q.push_back(32'h8080_8000);
    run_frame(100, 100, 0);

    // Partial flush
    configure(1, 0, 0, 5);
    set_psums('{1, 1, 1, 1, 1, 1});
    exp_q.push_back(32'h8181_8181);
    exp_q.push_back(32'h8080_8181);
    run_frame(100, 100, 0);

    // Backpressure with a pending word held for 5 cycles
    configure(1, 0, 0, 7);
    set_psums('{1, 2, 3, 4, 5, 6, 7, 8});
    exp_q.push_back(32'h8483_8281);
    exp_q.push_back(32'h8887_8685);
    run_frame(100, 100, 5);

    // Reset mid-frame after two accepts
    configure(1, 0, 0, 3);
    @(negedge clk); ipsum_valid = 1'b1; ipsum = 32'd5; out_ready = 1'b1;
    @(negedge clk); ipsum = 32'd6;
    @(negedge clk); ipsum_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(ipsum_ready), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ipsum_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("postrst_ready", 32'(ipsum_ready), 32'd0);
      chk("postrst_no_out", 32'(out_valid), 32'd0);
    end
    ipsum_valid = 1'b0;
    configure(1, 0, 0, 3);
    set_psums('{1, -1, 127, -128});
    exp_q.push_back(32'h00FF_7F81);
    run_frame(100, 100, 0);

    // Randomized frames against the reference model
    for (int f = 0; f < 24; f++) begin
      scale = ($urandom_range(3) == 0) ? int'($urandom_range(65535)) : int'($urandom_range(8));
      shift = int'($urandom_range(31));
      if (f % 3 == 0) shift = int'($urandom_range(4));
      relu  = 1'($urandom_range(1));
      len   = int'($urandom_range(40));
      psums.delete();
      for (int i = 0; i <= len; i++)
        psums.push_back($urandom_range(1) ? int'($urandom) : int'($urandom_range(600)) - 300);
      configure(scale, shift, relu, len);
      model_words(scale, shift, relu);
      run_frame(int'($urandom_range(40, 100)), int'($urandom_range(40, 100)),
                int'($urandom_range(3)));
    end

    // Maximum frame length at full rate
    psums.delete();
    for (int i = 0; i < 1024; i++) psums.push_back(int'($urandom_range(400)) - 200);
    configure(1, 1, 0, 1023);
    model_words(1, 1, 0);
    run_frame(100, 100, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
